// File: rtl/test_card_gradient_checker.sv
// -----------------------------------------------------------------------------
// test_card_gradient_checker
//
// Sink-side checker for the gradient test card. Regenerates the expected
// gradient from internal x/y counters and compares every active pixel of the
// incoming RGB stream, then reports a per-frame verdict and a saturating
// error count.
//
// Expected pixel (8-bit modulo):
//   red = y[7:0] + x[5:0], green = 8'h10 + y[7:0], blue = 8'h4C + y[7:0]
//
// Handshake: there is no back-pressure. i_de qualifies the pixel on
// i_red/i_green/i_blue in the same cycle; i_frame is a one-cycle pulse marking
// frame start and takes effect before an i_de in the same cycle, so that pixel
// is (0,0) of the new frame.
//
// Optional feature (macro TEST_CARD_CHECKER_FIRST_ERR_EN): latch x/y of the
// first pixel mismatch of each frame and present them at o_frame_done
// (16'hFFFF when the frame had none). Without the macro both read 0.
//
// Ports
//   i_pix_clk               pixel clock
//   i_rst_n                 asynchronous active-low reset
//   i_frame                 frame-start pulse
//   i_de                    active-pixel qualifier
//   i_red/i_green/i_blue    pixel colour
//   o_frame_done            one-cycle pulse, verdict valid
//   o_frame_pass            verdict, held until next o_frame_done
//   o_err_count             mismatches of the last reported frame (saturating)
//   o_locked                sticky, set by the first i_frame
//   o_first_x/o_first_y     first mismatch position (optional feature)
//   o_dbg_state             current FSM state (IDLE=0 CHECK=1 REPORT=2 WAIT=3)
// -----------------------------------------------------------------------------
module test_card_gradient_checker #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ERR_W = 16
) (
  input  logic             i_pix_clk,
  input  logic             i_rst_n,
  input  logic             i_frame,
  input  logic             i_de,
  input  logic [7:0]       i_red,
  input  logic [7:0]       i_green,
  input  logic [7:0]       i_blue,
  output logic             o_frame_done,
  output logic             o_frame_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_locked,
  output logic [15:0]      o_first_x,
  output logic [15:0]      o_first_y,
  output logic [1:0]       o_dbg_state
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XW-1:0]   r_x, w_cmp_x, w_x_nxt;
  logic [YW-1:0]   r_y, w_cmp_y, w_y_nxt;
  logic            r_locked;
  logic [15:0]     w_cx, w_cy;
  logic [7:0]      w_exp_r, w_exp_g, w_exp_b;
  logic            w_pix, w_ovr, w_last, w_short, w_mis_pix;

  // stage 1: registered compare result plus frame-close markers
  logic            r_s1_mis;     // pixel mismatch or overrun
  logic            r_s1_pixerr;  // pixel mismatch only (has coordinates)
  logic            r_s1_post;    // close frame including this entry
  logic            r_s1_pre;     // close frame excluding this entry (short frame)

  // stage 2: accumulator and reported verdict
  logic [ERR_W-1:0] r_acc, w_acc_inc;
  logic             r_done, r_pass;
  logic [ERR_W-1:0] r_err;

  // A frame start re-bases the compare position to (0,0) in the same cycle.
  assign w_cmp_x   = i_frame ? '0 : r_x;
  assign w_cmp_y   = i_frame ? '0 : r_y;
  assign w_pix     = i_de && (i_frame || (r_state == S_CHECK));
  // Stray pixels after a frame verdict count against the next frame.
  assign w_ovr     = i_de && !i_frame && ((r_state == S_REPORT) || (r_state == S_WAIT));
  assign w_last    = w_pix && !i_frame && (r_x == XW'(H_RES - 1)) && (r_y == YW'(V_RES - 1));
  assign w_short   = i_frame && (r_state == S_CHECK);

  assign w_cx      = 16'(w_cmp_x);
  assign w_cy      = 16'(w_cmp_y);
  assign w_exp_r   = w_cy[7:0] + {2'b00, w_cx[5:0]};
  assign w_exp_g   = 8'h10 + w_cy[7:0];
  assign w_exp_b   = 8'h4C + w_cy[7:0];
  assign w_mis_pix = (i_red != w_exp_r) || (i_green != w_exp_g) || (i_blue != w_exp_b);

  always_comb begin
    w_x_nxt = w_cmp_x;
    w_y_nxt = w_cmp_y;
    if (w_pix) begin
      if (w_cmp_x == XW'(H_RES - 1)) begin
        w_x_nxt = '0;
        w_y_nxt = w_cmp_y + YW'(1);
      end else begin
        w_x_nxt = w_cmp_x + XW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_frame) begin
      w_next = S_CHECK;
    end else begin
      case (r_state)
        S_CHECK:  if (w_last) w_next = S_REPORT;
        S_REPORT: w_next = S_WAIT;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state <= w_next;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      if (i_frame) r_locked <= 1'b1;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_mis    <= 1'b0;
      r_s1_pixerr <= 1'b0;
      r_s1_post   <= 1'b0;
      r_s1_pre    <= 1'b0;
    end else begin
      r_s1_mis    <= (w_pix && w_mis_pix) || w_ovr;
      r_s1_pixerr <= w_pix && w_mis_pix;
      r_s1_post   <= w_last;
      r_s1_pre    <= w_short;
    end
  end

  assign w_acc_inc = (r_s1_mis && (r_acc != {ERR_W{1'b1}})) ? r_acc + ERR_W'(1) : r_acc;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_s1_post) begin
        r_done <= 1'b1;
        r_pass <= (w_acc_inc == '0);
        r_err  <= w_acc_inc;
        r_acc  <= '0;
      end else if (r_s1_pre) begin
        // The stage-1 entry here is the first pixel of the new frame.
        r_done <= 1'b1;
        r_pass <= 1'b0;
        r_err  <= r_acc;
        r_acc  <= ERR_W'(r_s1_mis);
      end else begin
        r_acc  <= w_acc_inc;
      end
    end
  end

`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
  logic [15:0] r_s1_x, r_s1_y;
  logic        r_fe_vld;
  logic [15:0] r_fe_x, r_fe_y;
  logic [15:0] r_first_x, r_first_y;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_fe_vld  <= 1'b0;
      r_fe_x    <= '0;
      r_fe_y    <= '0;
      r_first_x <= '0;
      r_first_y <= '0;
    end else begin
      r_s1_x <= w_cx;
      r_s1_y <= w_cy;
      if (r_s1_post) begin
        r_first_x <= r_fe_vld ? r_fe_x : (r_s1_pixerr ? r_s1_x : 16'hFFFF);
        r_first_y <= r_fe_vld ? r_fe_y : (r_s1_pixerr ? r_s1_y : 16'hFFFF);
        r_fe_vld  <= 1'b0;
      end else if (r_s1_pre) begin
        r_first_x <= r_fe_vld ? r_fe_x : 16'hFFFF;
        r_first_y <= r_fe_vld ? r_fe_y : 16'hFFFF;
        r_fe_vld  <= r_s1_pixerr;
        r_fe_x    <= r_s1_x;
        r_fe_y    <= r_s1_y;
      end else if (r_s1_pixerr && !r_fe_vld) begin
        r_fe_vld  <= 1'b1;
        r_fe_x    <= r_s1_x;
        r_fe_y    <= r_s1_y;
      end
    end
  end

  assign o_first_x = r_first_x;
  assign o_first_y = r_first_y;
`else
  assign o_first_x = '0;
  assign o_first_y = '0;
`endif

  assign o_frame_done = r_done;
  assign o_frame_pass = r_pass;
  assign o_err_count  = r_err;
  assign o_locked     = r_locked;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_test_card_gradient_checker.sv
module tb_test_card_gradient_checker;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int EW   = 2;
  localparam int EMAX = 3;
  localparam int H2   = 64;
  localparam int V2   = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst_n;
  always #5 clk = ~clk;

  // main instance (small frame, 2-bit error counter)
  logic          i_frame, i_de;
  logic [7:0]    i_red, i_green, i_blue;
  logic          o_frame_done, o_frame_pass, o_locked;
  logic [EW-1:0] o_err_count;
  logic [15:0]   o_first_x, o_first_y;
  logic [1:0]    o_dbg_state;

  // wrap instance (64x256)
  logic          wr_frame, wr_de;
  logic [7:0]    wr_red, wr_green, wr_blue;
  logic          wo_done, wo_pass, wo_locked;
  logic [15:0]   wo_err, wo_fx, wo_fy;
  logic [1:0]    wo_state;

  test_card_gradient_checker #(.H_RES(H), .V_RES(V), .ERR_W(EW)) u_dut (
    .i_pix_clk(clk), .i_rst_n(i_rst_n), .i_frame(i_frame), .i_de(i_de),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_frame_done(o_frame_done), .o_frame_pass(o_frame_pass),
    .o_err_count(o_err_count), .o_locked(o_locked),
    .o_first_x(o_first_x), .o_first_y(o_first_y), .o_dbg_state(o_dbg_state)
  );

  test_card_gradient_checker #(.H_RES(H2), .V_RES(V2), .ERR_W(16)) u_wrap (
    .i_pix_clk(clk), .i_rst_n(i_rst_n), .i_frame(wr_frame), .i_de(wr_de),
    .i_red(wr_red), .i_green(wr_green), .i_blue(wr_blue),
    .o_frame_done(wo_done), .o_frame_pass(wo_pass),
    .o_err_count(wo_err), .o_locked(wo_locked),
    .o_first_x(wo_fx), .o_first_y(wo_fy), .o_dbg_state(wo_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  // {due[80:49], pass[48], err[47:32], first_x[31:16], first_y[15:0]}
  logic [80:0] exp_q[$];

  // reference model: frame as a pixel index, not as counters or pipeline
  bit m_locked = 0, m_active = 0, m_fe = 0;
  int m_n = 0, m_errs = 0, m_pend = 0, m_fx = 0, m_fy = 0;
  bit h_pass = 0;
  int h_err = 0, h_fx = 0, h_fy = 0;

  function automatic logic [23:0] exp_pix(input int x, input int y);
    int r, g, b;
    r = (y + (x % 64)) % 256;
    g = (16 + y) % 256;
    b = (76 + y) % 256;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic int sat(input int v);
    return (v > EMAX) ? EMAX : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_verdict(input bit pass);
    exp_q.push_back({32'(cyc + 1), pass, 16'(m_errs),
                     m_fe ? 16'(m_fx) : 16'hFFFF, m_fe ? 16'(m_fy) : 16'hFFFF});
  endtask

  task automatic model_step(input bit fr, input bit de, input logic [23:0] pix);
    int x, y;
    if (fr) begin
      if (m_active) push_verdict(1'b0);
      m_locked = 1; m_active = 1; m_n = 0; m_errs = m_pend; m_pend = 0; m_fe = 0;
    end
    if (de && m_locked) begin
      if (m_active) begin
        x = m_n % H;
        y = m_n / H;
        if (pix !== exp_pix(x, y)) begin
          m_errs = sat(m_errs + 1);
          if (!m_fe) begin m_fe = 1; m_fx = x; m_fy = y; end
        end
        m_n++;
        if (m_n == H * V) begin
          push_verdict(m_errs == 0);
          m_active = 0;
        end
      end else begin
        m_pend = sat(m_pend + 1);
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_locked = 0; m_active = 0; m_fe = 0; m_n = 0; m_errs = 0; m_pend = 0;
    h_pass = 0; h_err = 0; h_fx = 0; h_fy = 0;
  endtask

  task automatic check_outputs();
    logic [80:0] v;
    bit due;
    int exp_fx, exp_fy;
    due = 0;
    while (exp_q.size() > 0) begin
      v = exp_q[0];
      if (int'(v[80:49]) < cyc) void'(exp_q.pop_front());
      else break;
    end
    if (exp_q.size() > 0) begin
      v = exp_q[0];
      if (int'(v[80:49]) == cyc) begin
        due = 1;
        void'(exp_q.pop_front());
        h_pass = v[48]; h_err = int'(v[47:32]); h_fx = int'(v[31:16]); h_fy = int'(v[15:0]);
      end
    end
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    exp_fx = h_fx; exp_fy = h_fy;
`else
    exp_fx = 0; exp_fy = 0;
`endif
    chk("frame_done", 32'(o_frame_done), 32'(due));
    chk("frame_pass", 32'(o_frame_pass), 32'(h_pass));
    chk("err_count", 32'(o_err_count), 32'(h_err));
    chk("first_x", 32'(o_first_x), 32'(exp_fx));
    chk("first_y", 32'(o_first_y), 32'(exp_fy));
    chk("locked", 32'(o_locked), 32'(m_locked));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit fr, input bit de, input logic [23:0] pix);
    i_frame = fr; i_de = de; {i_red, i_green, i_blue} = pix;
    @(posedge clk); #1;
    model_step(fr, de, pix);
    check_outputs();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 24'($urandom));
  endtask

  // mode: -1 random, 0 = i_frame on its own cycle, 1 = i_frame with pixel 0
  task automatic drive_frame(input int npix, input logic [31:0] bad_mask,
                             input int bad_pct, input int gap_pct, input int mode);
    bit with_pix;
    logic [23:0] pix;
    with_pix = (mode < 0) ? 1'($urandom_range(0, 1)) : (mode == 1);
    if (!with_pix) step(1'b1, 1'b0, 24'($urandom));
    for (int k = 0; k < npix; k++) begin
      if (k > 0) while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, 24'($urandom));
      pix = exp_pix(k % H, k / H);
      if (k < 32 && bad_mask[k]) pix = pix ^ 24'h070000;
      else if ($urandom_range(0, 99) < bad_pct) pix = pix ^ (24'h1 << $urandom_range(0, 23));
      step(with_pix && (k == 0), 1'b1, pix);
    end
  endtask

  task automatic wstep(input bit fr, input bit de, input logic [23:0] pix);
    wr_frame = fr; wr_de = de; {wr_red, wr_green, wr_blue} = pix;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, 32'(o_frame_done), 0);
    chk({tag, "_pass"}, 32'(o_frame_pass), 0);
    chk({tag, "_err"}, 32'(o_err_count), 0);
    chk({tag, "_locked"}, 32'(o_locked), 0);
    chk({tag, "_fx"}, 32'(o_first_x), 0);
    chk({tag, "_fy"}, 32'(o_first_y), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] wp;
    i_rst_n = 1'b0;
    i_frame = 0; i_de = 0; i_red = 0; i_green = 0; i_blue = 0;
    wr_frame = 0; wr_de = 0; wr_red = 0; wr_green = 0; wr_blue = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_wrap_locked", 32'(wo_locked), 0);
    i_rst_n = 1'b1;

    // pixels before the first frame start are ignored
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, exp_pix(k, 0));

    // clean frame
    drive_frame(12, 32'h0, 0, 0, -1);
    idle(3);

    // pixel (2,1) red 8'h03 -> 8'h04
    drive_frame(12, 32'h40, 0, 0, 0);
    idle(3);

    // short frame of 7 pixels, then a clean frame
    drive_frame(7, 32'h0, 0, 0, 1);
    drive_frame(12, 32'h0, 0, 0, 0);
    idle(3);

    // two overruns in WAIT plus three bad pixels -> saturates
    step(1'b0, 1'b1, 24'($urandom));
    step(1'b0, 1'b1, 24'($urandom));
    drive_frame(12, 32'h124, 0, 0, -1);
    idle(3);

    // frame starts in the REPORT cycle, both alignments
    drive_frame(12, 32'h0, 0, 0, 1);
    drive_frame(12, 32'h0, 0, 0, 0);
    drive_frame(12, 32'h800, 0, 0, 1);
    idle(3);

    // randomized frames: short/full, gaps, corruption, overruns
    for (int r = 0; r < 30; r++) begin
      drive_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 12,
                  32'h0, 8, 20, -1);
      if ($urandom_range(0, 2) == 0)
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b0, 1'b1, 24'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(3);

    // asynchronous reset in the middle of a frame
    drive_frame(5, 32'h0, 0, 0, 1);
    #2;
    i_rst_n = 1'b0;
    i_frame = 0; i_de = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, exp_pix(k % H, 0));
    drive_frame(12, 32'h0, 0, 0, -1);
    idle(3);

    // 64x256 frame: exercises 8-bit wrap of red/green/blue
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < H2 * V2; n++) begin
        wp = exp_pix(n % H2, n / H2);
        if (f == 1 && n == H2 * V2 - 1) wp = wp ^ 24'h000100;
        wstep(n == 0, 1'b1, wp);
      end
      chk("wrap_done_early", 32'(wo_done), 0);
      wstep(1'b0, 1'b0, 24'h0);
      chk("wrap_done", 32'(wo_done), 1);
      chk("wrap_pass", 32'(wo_pass), (f == 0) ? 1 : 0);
      chk("wrap_err", 32'(wo_err), (f == 0) ? 0 : 1);
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
      chk("wrap_first_x", 32'(wo_fx), (f == 0) ? 32'hFFFF : 63);
      chk("wrap_first_y", 32'(wo_fy), (f == 0) ? 32'hFFFF : 255);
`else
      chk("wrap_first_x", 32'(wo_fx), 0);
`endif
      wstep(1'b0, 1'b0, 24'h0);
      chk("wrap_done_pulse", 32'(wo_done), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
